d_serial_tx: RTL and testbench
==============================

Name: d_serial_tx

Overview:
- Parallel-to-serial bit transmitter that drives a single-bit `d` line for the team's FSM-based D flip-flop and other bit-level samplers.
- Accepts a word through a valid/ready handshake and shifts it out one bit at a time.
- Holds each bit for BIT_CYCLES clocks so the downstream sampler sees it stable across its sample cadence.
- Optional even-parity bit is appended after the data bits.

Parameters:
- WIDTH, 8: data word width in bits; must be >= 1.
- BIT_CYCLES, 2: clocks each bit is held on d_out; must be >= 1.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- PARITY_EN, 0: 1 appends an even-parity bit (XOR of all data bits) after the data bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- data_in  input  WIDTH  word to transmit; sampled only on handshake.
- valid_in  input  1  word available.
- ready_out  output  1  transmitter can accept a word.
- d_out  output  1  serial bit stream.
- bit_strobe  output  1  high in the first cycle of each transmitted bit.
- frame_active  output  1  high while bits are being driven.
- done  output  1  one-cycle pulse after the last bit of a frame.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a rising edge) forces the following in the next cycle:
  - state IDLE, ready_out=1, d_out=0, bit_strobe=0, frame_active=0, done=0;
  - shift register, bit counter and hold counter cleared.
- Frame length is NBITS = WIDTH + PARITY_EN.
- States:
  - IDLE: ready_out=1, d_out=0. A handshake (valid_in && ready_out at edge N) captures data_in into a shift register, computes parity if enabled, clears the counters and moves to SHIFT. ready_out drops to 0 from cycle N+1.
  - SHIFT:
    - frame_active=1 and d_out = current bit.
    - hold_cnt counts 0..BIT_CYCLES-1; bit_strobe=1 exactly when hold_cnt==0.
    - When hold_cnt==BIT_CYCLES-1: if bit_cnt==NBITS-1, go to DONE; otherwise shift to the next bit, increment bit_cnt and reset hold_cnt.
  - DONE: one cycle with done=1, d_out=0, frame_active=0, ready_out=0. Then go to IDLE.
- Timing for a handshake at edge N:
  - bit k (k=0..NBITS-1) drives cycles N+1+k*BIT_CYCLES through N+(k+1)*BIT_CYCLES;
  - done is high in cycle N+NBITS*BIT_CYCLES+1;
  - ready_out returns high in cycle N+NBITS*BIT_CYCLES+2.
- Bit order: data bits are sent in MSB_FIRST order. The parity bit is always last.
- Parity is even: the total number of ones over data+parity is even.
- valid_in while ready_out==0 is ignored, with no queuing. data_in changes after the handshake do not affect the frame in flight.
- BIT_CYCLES==1: bit_strobe is high every SHIFT cycle and d_out changes every cycle.
- Reset mid-frame aborts the frame: no done pulse, and the outputs follow the reset values above from the next cycle.
- Reset has priority over a simultaneous handshake.
- Back-to-back frames are separated by at least the DONE cycle plus one IDLE cycle. The minimum period is NBITS*BIT_CYCLES+2 clocks.

Test Plan:
- Reset then idle, default parameters: release reset and hold valid_in=0 for 10 cycles -> ready_out=1, d_out=0, done=0, frame_active=0 throughout.
- Basic MSB-first frame (WIDTH=8, BIT_CYCLES=2, MSB_FIRST=1), data 0xA5 handshaked at edge N:
  - d_out over cycles N+1..N+16 is 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1;
  - bit_strobe high at N+1, N+3, ..., N+15;
  - done high only at N+17; ready_out high again at N+18.
- LSB-first with parity (MSB_FIRST=0, PARITY_EN=1, BIT_CYCLES=1), data 0x07:
  - d_out over N+1..N+9 is 1,1,1,0,0,0,0,0,1 (parity=1);
  - done at N+10.
  - Repeat with 0xA5 -> parity bit 0.
- Busy and back-to-back: assert valid_in continuously with data 0x3C and then 0xC3 (data_in switched at N+1):
  - the first frame is unaffected by the switch;
  - the second handshake occurs at edge N+18 and transmits 0xC3 correctly.
- Reset mid-frame: pull reset low at cycle N+7 of a 0xFF frame:
  - next cycle d_out=0, frame_active=0, ready_out=1;
  - no done pulse;
  - a subsequent 0x81 frame transmits cleanly.

Source files
------------

// File: rtl/d_serial_tx.sv
// Parallel-to-serial bit transmitter with per-bit hold time
// and optional trailing even-parity bit.
module d_serial_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 2,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_EN  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             d_out,
  output logic             bit_strobe,
  output logic             frame_active,
  output logic             done
);

  localparam int NBITS = WIDTH + ((PARITY_EN != 0) ? 1 : 0);
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [NBITS-1:0] r_shift;
  logic [NBITS-1:0] w_shift_nx;
  logic [NBITS-1:0] w_frame;
  logic [BW-1:0]    r_bit_cnt;
  logic [BW-1:0]    w_bit_cnt_nx;
  logic [HW-1:0]    r_hold_cnt;
  logic [HW-1:0]    w_hold_cnt_nx;
  logic             r_ready;
  logic             r_d;
  logic             r_strobe;
  logic             r_active;
  logic             r_done;

  // Frame is laid out so the first bit on the wire sits at the MSB.
  always_comb begin
    w_frame = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (MSB_FIRST != 0) begin
        w_frame[NBITS-1-j] = data_in[WIDTH-1-j];
      end else begin
        w_frame[NBITS-1-j] = data_in[j];
      end
    end
    if (PARITY_EN != 0) begin
      w_frame[0] = ^data_in;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_shift_nx    = r_shift;
    w_bit_cnt_nx  = r_bit_cnt;
    w_hold_cnt_nx = r_hold_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (valid_in && r_ready) begin
          w_state_nx    = S_SHIFT;
          w_shift_nx    = w_frame;
          w_bit_cnt_nx  = '0;
          w_hold_cnt_nx = '0;
        end
      end
      S_SHIFT: begin
        if (r_hold_cnt == LAST_HOLD) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nx = S_DONE;
          end else begin
            w_shift_nx    = r_shift << 1;
            w_bit_cnt_nx  = r_bit_cnt + BW'(1);
            w_hold_cnt_nx = '0;
          end
        end else begin
          w_hold_cnt_nx = r_hold_cnt + HW'(1);
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_hold_cnt <= '0;
      r_ready    <= 1'b1;
      r_d        <= 1'b0;
      r_strobe   <= 1'b0;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_shift    <= w_shift_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_hold_cnt <= w_hold_cnt_nx;
      r_ready    <= (w_state_nx == S_IDLE);
      r_d        <= (w_state_nx == S_SHIFT) && w_shift_nx[NBITS-1];
      r_strobe   <= (w_state_nx == S_SHIFT) && (w_hold_cnt_nx == '0);
      r_active   <= (w_state_nx == S_SHIFT);
      r_done     <= (w_state_nx == S_DONE);
    end
  end

  assign ready_out    = r_ready;
  assign d_out        = r_d;
  assign bit_strobe   = r_strobe;
  assign frame_active = r_active;
  assign done         = r_done;

endmodule

// File: tb/tb_d_serial_tx.sv
// Bench for d_serial_tx: three parameterisations checked every
// cycle against a frame-timeline model plus literal frame vectors.
module tb_d_serial_tx;

  localparam int PW[3] = '{8, 8, 5};
  localparam int PB[3] = '{2, 1, 3};
  localparam int PM[3] = '{1, 0, 1};
  localparam int PP[3] = '{0, 1, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dat[3];
  logic [2:0] vld;
  logic [2:0] rdy, dq, stb, act, dn;
  logic       chk_en = 1'b0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         t[3] = '{0, 0, 0};
  logic [15:0] bits[3];

  always #5 clk = ~clk;

  d_serial_tx #(.WIDTH(PW[0]), .BIT_CYCLES(PB[0]),
    .MSB_FIRST(PM[0]), .PARITY_EN(PP[0])) u0 (
    .clk(clk), .reset(rst), .data_in(dat[0]),
    .valid_in(vld[0]), .ready_out(rdy[0]), .d_out(dq[0]),
    .bit_strobe(stb[0]), .frame_active(act[0]), .done(dn[0]));

  d_serial_tx #(.WIDTH(PW[1]), .BIT_CYCLES(PB[1]),
    .MSB_FIRST(PM[1]), .PARITY_EN(PP[1])) u1 (
    .clk(clk), .reset(rst), .data_in(dat[1]),
    .valid_in(vld[1]), .ready_out(rdy[1]), .d_out(dq[1]),
    .bit_strobe(stb[1]), .frame_active(act[1]), .done(dn[1]));

  d_serial_tx #(.WIDTH(PW[2]), .BIT_CYCLES(PB[2]),
    .MSB_FIRST(PM[2]), .PARITY_EN(PP[2])) u2 (
    .clk(clk), .reset(rst), .data_in(dat[2][4:0]),
    .valid_in(vld[2]), .ready_out(rdy[2]), .d_out(dq[2]),
    .bit_strobe(stb[2]), .frame_active(act[2]), .done(dn[2]));

  task automatic check(input string name, input logic [31:0] a,
                       input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, a, e);
  endtask

  // bits[k] is the k-th bit on the wire
  function automatic logic [15:0] make_bits(input logic [7:0] d,
      input int w, input int msb, input int par);
    logic [15:0] b;
    int ones;
    b = '0;
    ones = 0;
    for (int k = 0; k < w; k++) begin
      b[k] = (msb != 0) ? d[w-1-k] : d[k];
      ones += int'(d[k]);
    end
    if (par != 0) b[w] = 1'((ones % 2));
    return b;
  endfunction

  // {ready, d, strobe, active, done} at t cycles after the handshake
  function automatic logic [4:0] exp_out(input int tt, input int nb,
      input int bc, input logic [15:0] b);
    if (tt == 0) return 5'b10000;
    if (tt <= nb * bc)
      return {1'b0, b[(tt-1)/bc], ((tt-1) % bc) == 0, 1'b1, 1'b0};
    return 5'b00001;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) t[i] <= 0;
      else if (t[i] == 0) begin
        if (vld[i]) begin
          t[i] <= 1;
          bits[i] <= make_bits(dat[i], PW[i], PM[i], PP[i]);
        end
      end else if (t[i] == (PW[i] + PP[i]) * PB[i] + 1) t[i] <= 0;
      else t[i] <= t[i] + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model_u%0d_t%0d", i, t[i]),
          32'({rdy[i], dq[i], stb[i], act[i], dn[i]}),
          32'(exp_out(t[i], PW[i] + PP[i], PB[i], bits[i])));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      vld[2] = 1'($urandom_range(0, 1));
      dat[2] = 8'($urandom);
    end
  end

  task automatic rec0(output logic [15:0] s, output logic [15:0] b);
    for (int k = 0; k < 16; k++) begin
      s[15-k] = dq[0];
      b[15-k] = stb[0];
      @(negedge clk);
    end
  endtask

  task automatic start(input int i, input logic [7:0] d);
    dat[i] = d;
    vld[i] = 1'b1;
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  initial begin
    logic [15:0] s, b;
    logic [8:0] s9;
    logic seen;
    rst = 1'b0;
    vld[1:0] = 2'b00;
    dat[0] = 8'h00;
    dat[1] = 8'h00;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_ready", 32'(rdy[0]), 32'd1);
    check("idle_d", 32'({dq[0], act[0], dn[0]}), 32'd0);

    start(0, 8'hA5);
    rec0(s, b);
    check("a5_msb_bits", 32'(s), 32'h0000_CC33);
    check("a5_strobe", 32'(b), 32'h0000_AAAA);
    check("a5_done", 32'(dn[0]), 32'd1);
    @(negedge clk);
    check("a5_ready_back", 32'(rdy[0]), 32'd1);

    start(1, 8'h07);
    for (int k = 0; k < 9; k++) begin
      s9[8-k] = dq[1];
      @(negedge clk);
    end
    check("07_lsb_par_bits", 32'(s9), 32'(9'b111000001));
    check("07_done", 32'(dn[1]), 32'd1);
    @(negedge clk);
    start(1, 8'hA5);
    for (int k = 0; k < 9; k++) begin
      s9[8-k] = dq[1];
      @(negedge clk);
    end
    check("a5_lsb_par_bits", 32'(s9), 32'(9'b101001010));
    check("a5p_done", 32'(dn[1]), 32'd1);
    @(negedge clk);

    dat[0] = 8'h3C;
    vld[0] = 1'b1;
    @(negedge clk);
    dat[0] = 8'hC3;
    rec0(s, b);
    check("b2b_first_3c", 32'(s), 32'h0000_0FF0);
    check("b2b_done", 32'(dn[0]), 32'd1);
    @(negedge clk);
    check("b2b_ready_gap", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    vld[0] = 1'b0;
    rec0(s, b);
    check("b2b_second_c3", 32'(s), 32'h0000_F00F);
    @(negedge clk);
    @(negedge clk);

    start(0, 8'hFF);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_d", 32'(dq[0]), 32'd0);
    check("rst_mid_active", 32'(act[0]), 32'd0);
    check("rst_mid_ready", 32'(rdy[0]), 32'd1);
    rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      seen |= dn[0];
      @(negedge clk);
    end
    check("rst_no_done", 32'(seen), 32'd0);
    start(0, 8'h81);
    rec0(s, b);
    check("after_rst_81", 32'(s), 32'h0000_C003);
    check("after_rst_done", 32'(dn[0]), 32'd1);
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

endmodule
